// File: rtl/bnn_conv_pkg.sv
// Shared definitions for the convolution window generator: frame FSM
// encoding and window indexing helpers.
package bnn_conv_pkg;

  typedef enum logic [2:0] {
    S_FILL = 3'b001,
    S_RUN  = 3'b010,
    S_LAST = 3'b100
  } frame_state_e;

  // Bottom-right anchor coordinate of the final window along one axis.
  function automatic int last_anchor(input int size, input int k, input int stride);
    return (k - 1) + ((size - k) / stride) * stride;
  endfunction

  function automatic int win_elem_lsb(input int n, input int r, input int c,
                                      input int k, input int dw);
    return ((n * k + r) * k + c) * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Per-channel line storage: K-1 column-indexed line buffers feeding a K x K
// window shift register. win_next is the window after the current shift.
module conv_line_buffer
  import bnn_conv_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int K          = 3,
  parameter int IMG_W      = 9,
  localparam int CW        = $clog2(IMG_W)
) (
  input  logic                      clk,
  input  logic                      shift_en,
  input  logic [CW-1:0]             col_idx,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic [K*K*DATA_WIDTH-1:0] win_next
);

  logic [DATA_WIDTH-1:0] line_q    [K-1][IMG_W];
  logic [DATA_WIDTH-1:0] win_q     [K][K];
  logic [DATA_WIDTH-1:0] win_d     [K][K];
  logic [DATA_WIDTH-1:0] col_vec_s [K];

  // Column vector oldest-row first, then shift it in at the right edge.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_vec_s[r] = line_q[r][col_idx];
    end
    col_vec_s[K-1] = din;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
      win_d[r][K-1] = col_vec_s[r];
    end
  end

  always_comb begin
    win_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_next[win_elem_lsb(0, r, c, K, DATA_WIDTH) +: DATA_WIDTH] = win_d[r][c];
      end
    end
  end

  // Storage is datapath only; contents before the first full rows are never used.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int r = 0; r < K - 2; r++) begin
        line_q[r][col_idx] <= line_q[r+1][col_idx];
      end
      line_q[K-2][col_idx] <= din;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding K x K window generator over a raster pixel stream, with a single
// registered output stage and valid/ready handshaking on both sides.
module conv_window_gen
  import bnn_conv_pkg::*;
#(
  parameter int CH_NUM     = 6,
  parameter int DATA_WIDTH = 6,
  parameter int K          = 3,
  parameter int IMG_W      = 9,
  parameter int IMG_H      = 9,
  parameter int STRIDE     = 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               iclr,
  input  logic                               ivalid,
  output logic                               iready,
  input  logic [CH_NUM*DATA_WIDTH-1:0]       idata,
  output logic                               ovalid,
  input  logic                               oready,
  output logic [CH_NUM*K*K*DATA_WIDTH-1:0]   dout,
  output logic                               olast
);

  localparam int   CW       = $clog2(IMG_W);
  localparam int   RW       = $clog2(IMG_H);
  localparam int   WIN_W    = K * K * DATA_WIDTH;
  localparam int   LAST_ROW = last_anchor(IMG_H, K, STRIDE);
  localparam int   LAST_COL = last_anchor(IMG_W, K, STRIDE);
  localparam logic KM1_LSB  = 1'((K - 1) % 2);

  frame_state_e                 state_q, state_d;
  logic [CW-1:0]                col_cnt_q, col_cnt_d;
  logic [RW-1:0]                row_cnt_q, row_cnt_d;
  logic                         ovalid_q, ovalid_d;
  logic                         olast_q, olast_d;
  logic [CH_NUM*WIN_W-1:0]      dout_q, dout_d;
  logic [CH_NUM-1:0][WIN_W-1:0] chan_win_s;
  logic xfer_s, col_end_s, row_end_s, win_done_s, pending_last_s;

  assign iready = ~ovalid_q | oready;
  assign ovalid = ovalid_q;
  assign olast  = olast_q;
  assign dout   = dout_q;

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    conv_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .K          (K),
      .IMG_W      (IMG_W)
    ) u_lb (
      .clk      (clk),
      .shift_en (xfer_s),
      .col_idx  (col_cnt_q),
      .din      (idata[n*DATA_WIDTH +: DATA_WIDTH]),
      .win_next (chan_win_s[n])
    );
  end

  // Stride alignment only needs the LSB since STRIDE is 1 or 2.
  always_comb begin
    xfer_s         = ivalid & iready;
    col_end_s      = (col_cnt_q == CW'(IMG_W - 1));
    row_end_s      = (row_cnt_q == RW'(IMG_H - 1));
    pending_last_s = ovalid_q & olast_q;
    win_done_s     = xfer_s
                     && (row_cnt_q >= RW'(K - 1)) && (col_cnt_q >= CW'(K - 1))
                     && ((STRIDE == 1) || (row_cnt_q[0] == KM1_LSB))
                     && ((STRIDE == 1) || (col_cnt_q[0] == KM1_LSB));
  end

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (iclr) begin
      col_cnt_d = '0;
      row_cnt_d = '0;
    end else if (xfer_s) begin
      if (col_end_s) begin
        col_cnt_d = '0;
        row_cnt_d = row_end_s ? '0 : row_cnt_q + RW'(1);
      end else begin
        col_cnt_d = col_cnt_q + CW'(1);
      end
    end else begin
      col_cnt_d = col_cnt_q;
    end
  end

  // A new window may overwrite the register only when it is empty or being taken.
  always_comb begin
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    dout_d   = dout_q;
    if (iclr) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end else if (win_done_s) begin
      ovalid_d = 1'b1;
      olast_d  = (row_cnt_q == RW'(LAST_ROW)) && (col_cnt_q == CW'(LAST_COL));
      dout_d   = chan_win_s;
    end else if (oready) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (iclr) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL: begin
          if (xfer_s && col_end_s && (row_cnt_q == RW'(K - 2))) state_d = S_RUN;
          else state_d = S_FILL;
        end
        S_RUN: begin
          if (xfer_s && col_end_s && row_end_s) state_d = S_LAST;
          else state_d = S_RUN;
        end
        S_LAST: begin
          if (!pending_last_s || oready) state_d = S_FILL;
          else state_d = S_LAST;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  // State, counters and output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FILL;
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      ovalid_q  <= 1'b0;
      olast_q   <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      ovalid_q  <= ovalid_d;
      olast_q   <= olast_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: directed vector table on a raster
// frame plus randomized frames scored against a frame-level window model.
module tb_conv_window_gen;

  localparam int CH = 2, DW = 8, K = 3, W = 5, H = 5;
  localparam int IW = CH * DW;
  localparam int OW = CH * K * K * DW;

  logic clk = 1'b0, rstn = 1'b0, iclr = 1'b0, ivalid = 1'b0, oready = 1'b1;
  logic [IW-1:0] idata = '0;
  int sel = 0, ordy_mode = 0, gap_pct = 0;

  logic ivalid1, ivalid2, oready1, oready2, iready1, iready2;
  logic ovalid1, ovalid2, olast1, olast2;
  logic [OW-1:0] dout1, dout2;

  assign ivalid1 = ivalid & (sel == 0);
  assign ivalid2 = ivalid & (sel != 0);
  assign oready1 = (sel == 0) ? oready : 1'b1;
  assign oready2 = (sel != 0) ? oready : 1'b1;

  always #5 clk = ~clk;

  conv_window_gen #(.CH_NUM(CH), .DATA_WIDTH(DW), .K(K), .IMG_W(W), .IMG_H(H), .STRIDE(1)) dut1 (
    .clk(clk), .rstn(rstn), .iclr(iclr), .ivalid(ivalid1), .iready(iready1), .idata(idata),
    .ovalid(ovalid1), .oready(oready1), .dout(dout1), .olast(olast1));

  conv_window_gen #(.CH_NUM(CH), .DATA_WIDTH(DW), .K(K), .IMG_W(W), .IMG_H(H), .STRIDE(2)) dut2 (
    .clk(clk), .rstn(rstn), .iclr(iclr), .ivalid(ivalid2), .iready(iready2), .idata(idata),
    .ovalid(ovalid2), .oready(oready2), .dout(dout2), .olast(olast2));

  typedef struct { logic [OW-1:0] d; logic last; } win_t;
  typedef struct { int stride; int idx; int tl; int centre; bit last; } vec_t;

  win_t got1[$], got2[$], exp_q[$];
  logic [DW-1:0] frm [H][W][CH];
  int n_cmp = 0, n_err = 0;

  task automatic chk_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // oready pattern: 0 = always ready, 1 = random back-pressure, 2 = held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0: oready = 1'b1;
        1: oready = ($urandom_range(3) != 0);
        default: oready = 1'b0;
      endcase
    end
  end

  // Output monitor: collects accepted windows and checks hold-while-stalled.
  initial begin
    logic st1, st2, hl1, hl2;
    logic [OW-1:0] hd1, hd2;
    st1 = 1'b0; st2 = 1'b0; hl1 = 1'b0; hl2 = 1'b0; hd1 = '0; hd2 = '0;
    forever begin
      @(negedge clk);
      if (rstn && st1) begin
        chk_bit("hold_valid1", ovalid1, 1'b1);
        chk_vec("hold_dout1", dout1, hd1);
        chk_bit("hold_last1", olast1, hl1);
      end
      if (rstn && st2) begin
        chk_bit("hold_valid2", ovalid2, 1'b1);
        chk_vec("hold_dout2", dout2, hd2);
        chk_bit("hold_last2", olast2, hl2);
      end
      if (rstn && ovalid1 && oready1) got1.push_back('{d: dout1, last: olast1});
      if (rstn && ovalid2 && oready2) got2.push_back('{d: dout2, last: olast2});
      st1 = rstn & ovalid1 & ~oready1 & ~iclr;
      st2 = rstn & ovalid2 & ~oready2 & ~iclr;
      hd1 = dout1; hl1 = olast1; hd2 = dout2; hl2 = olast2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int cur_stride();
    return (sel != 0) ? 2 : 1;
  endfunction

  task automatic gen_frame(input bit raster);
    for (int i = 0; i < H * W; i++) begin
      frm[i / W][i % W][0] = raster ? DW'(i) : DW'($urandom);
      frm[i / W][i % W][1] = raster ? (DW'(i) ^ 8'h5A) : DW'($urandom);
    end
  endtask

  // Expected windows whose bottom-right pixel is among the first npix pixels.
  task automatic model(input int stride, input int npix);
    int nr, nc, top, left;
    win_t w;
    nr = (H - K) / stride + 1;
    nc = (W - K) / stride + 1;
    for (int wr = 0; wr < nr; wr++) begin
      for (int wc = 0; wc < nc; wc++) begin
        top = wr * stride;
        left = wc * stride;
        if ((top + K - 1) * W + left + K - 1 < npix) begin
          w.d = '0;
          for (int n = 0; n < CH; n++)
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++)
                w.d[((n * K + r) * K + c) * DW +: DW] = frm[top + r][left + c][n];
          w.last = (wr == nr - 1) && (wc == nc - 1);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic push_pixel(input logic [IW-1:0] px);
    bit acc;
    int guard;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      ivalid = 1'b0;
      @(posedge clk);
      #1;
    end
    ivalid = 1'b1;
    idata = px;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = (sel == 0) ? iready1 : iready2;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 400) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got iready=0 for %0d cycles required 1", guard);
        acc = 1'b1;
      end
    end
    ivalid = 1'b0;
  endtask

  task automatic send(input int npix);
    for (int i = 0; i < npix; i++) push_pixel({frm[i / W][i % W][1], frm[i / W][i % W][0]});
  endtask

  task automatic wait_out();
    int n;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n = (sel == 0) ? got1.size() : got2.size();
      if (n >= exp_q.size() && !((sel == 0) ? ovalid1 : ovalid2)) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_out(input string tag);
    win_t g[$];
    int m;
    g = (sel == 0) ? got1 : got2;
    chk_int({tag, "_count"}, g.size(), exp_q.size());
    m = (g.size() < exp_q.size()) ? g.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk_vec({tag, "_dout"}, g[i].d, exp_q[i].d);
      chk_bit({tag, "_olast"}, g[i].last, exp_q[i].last);
    end
    got1.delete();
    got2.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vt[8];
    win_t g[$];
    win_t w;
    logic [K*K*DW-1:0] ev;
    logic [OW-1:0] saved;

    vt[0] = '{1, 0,  0,  6, 1'b0};
    vt[1] = '{1, 1,  1,  7, 1'b0};
    vt[2] = '{1, 3,  5, 11, 1'b0};
    vt[3] = '{1, 8, 12, 18, 1'b1};
    vt[4] = '{2, 0,  0,  6, 1'b0};
    vt[5] = '{2, 1,  2,  8, 1'b0};
    vt[6] = '{2, 2, 10, 16, 1'b0};
    vt[7] = '{2, 3, 12, 18, 1'b1};

    // Reset state
    #12;
    chk_bit("rst_ovalid1", ovalid1, 1'b0);
    chk_bit("rst_olast1", olast1, 1'b0);
    chk_vec("rst_dout1", dout1, '0);
    chk_bit("rst_iready1", iready1, 1'b1);
    chk_bit("rst_ovalid2", ovalid2, 1'b0);
    chk_vec("rst_dout2", dout2, '0);
    chk_bit("rst_iready2", iready2, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed raster frames, stride 1 then stride 2
    for (int s = 0; s < 2; s++) begin
      sel = s;
      gen_frame(1'b1);
      model(cur_stride(), H * W);
      send(H * W);
      wait_out();
      g = (s == 0) ? got1 : got2;
      chk_int(s == 0 ? "count_s1" : "count_s2", g.size(), s == 0 ? 9 : 4);
      for (int t = 0; t < 8; t++) begin
        if (vt[t].stride == s + 1) begin
          if (vt[t].idx < g.size()) w = g[vt[t].idx];
          else begin
            w.d = '0;
            w.last = 1'b0;
          end
          for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
              ev[(r * K + c) * DW +: DW] = DW'(vt[t].tl + r * W + c);
          chk_vec("tbl_window", OW'(w.d[K*K*DW-1:0]), OW'(ev));
          chk_int("tbl_centre", int'(w.d[(1 * K + 1) * DW +: DW]), vt[t].centre);
          chk_bit("tbl_olast", w.last, vt[t].last);
        end
      end
      cmp_out("raster");
    end

    // Randomized frames with back-pressure and input gaps
    ordy_mode = 1;
    gap_pct = 20;
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < 2; s++) begin
        sel = s;
        gen_frame(1'b0);
        model(cur_stride(), H * W);
        send(H * W);
        wait_out();
        cmp_out("rand");
      end
    end
    ordy_mode = 0;
    gap_pct = 0;

    // Long stall while a window is pending
    sel = 0;
    ordy_mode = 2;
    gen_frame(1'b0);
    model(1, H * W);
    fork
      send(H * W);
      begin
        @(negedge clk);
        for (int i = 0; i < 200 && !ovalid1; i++) @(negedge clk);
        chk_bit("stall_seen_valid", ovalid1, 1'b1);
        saved = dout1;
        repeat (5) begin
          @(negedge clk);
          chk_bit("stall_ovalid", ovalid1, 1'b1);
          chk_vec("stall_dout", dout1, saved);
          chk_bit("stall_iready", iready1, 1'b0);
        end
        ordy_mode = 0;
      end
    join
    wait_out();
    cmp_out("stall");

    // Frame abort at pixel (3,2) together with a valid pixel
    sel = 0;
    gen_frame(1'b0);
    model(1, 3 * W + 2);
    send(3 * W + 2);
    ivalid = 1'b1;
    iclr = 1'b1;
    idata = {frm[3][2][1], frm[3][2][0]};
    @(posedge clk);
    #1;
    iclr = 1'b0;
    ivalid = 1'b0;
    @(negedge clk);
    chk_bit("clr_ovalid", ovalid1, 1'b0);
    chk_bit("clr_olast", olast1, 1'b0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    cmp_out("clr_partial");
    gen_frame(1'b0);
    model(1, H * W);
    send(H * W);
    wait_out();
    cmp_out("clr_fresh");

    // Two back-to-back frames
    gen_frame(1'b0);
    model(1, H * W);
    send(H * W);
    gen_frame(1'b0);
    model(1, H * W);
    send(H * W);
    wait_out();
    chk_int("b2b_expected", exp_q.size(), 18);
    cmp_out("b2b");

    // Asynchronous reset while a window is pending
    ordy_mode = 2;
    gen_frame(1'b0);
    send(2 * W + 3);
    @(negedge clk);
    chk_bit("prerst_ovalid", ovalid1, 1'b1);
    #3;
    rstn = 1'b0;
    #1;
    chk_bit("arst_ovalid", ovalid1, 1'b0);
    chk_bit("arst_olast", olast1, 1'b0);
    chk_vec("arst_dout", dout1, '0);
    chk_bit("arst_iready", iready1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #3;
    rstn = 1'b1;
    ordy_mode = 0;
    got1.delete();
    exp_q.delete();
    @(negedge clk);
    chk_bit("post_rst_iready", iready1, 1'b1);
    @(posedge clk);
    #1;
    gen_frame(1'b0);
    model(1, H * W);
    send(H * W);
    wait_out();
    cmp_out("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
